// File: rtl/csr_counter_wide_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_wide_if
// Description : CSR-side bus of the split wide hardware counter. The master
//               (CSR file) drives increment/write controls; the slave
//               (counter) returns both read halves, overflow and tick.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_counter_wide_if #(
    parameter int XLEN = 32
) ();
    logic            inc;
    logic            inhibit;
    logic            wr_en;
    logic            half_sel;
    logic [1:0]      rw_mode;
    logic [XLEN-1:0] wdata;
    logic            ovf_clr;
    logic [XLEN-1:0] rdata_lo;
    logic [XLEN-1:0] rdata_hi;
    logic            ovf;
    logic            tick;

    modport master (
        output inc, inhibit, wr_en, half_sel, rw_mode, wdata, ovf_clr,
        input  rdata_lo, rdata_hi, ovf, tick
    );

    modport slave (
        input  inc, inhibit, wr_en, half_sel, rw_mode, wdata, ovf_clr,
        output rdata_lo, rdata_hi, ovf, tick
    );
endinterface
`default_nettype wire

// File: rtl/csr_counter_wide.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_wide
// Description : WIDTH-bit hardware counter exposed as two XLEN-bit CSR halves
//               with CSRRW/CSRRS/CSRRC writes, increment inhibit, sticky
//               overflow and a registered tick pulse.
//               Optional feature macro: CSR_COUNTER_PRESCALE_EN (adds a
//               PRESCALE-event prescaler in front of the counter).
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter_wide #(
    parameter int               XLEN      = 32,
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               PRESCALE  = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    csr_counter_wide_if.slave   bus
);

    localparam int               c_hw  = WIDTH - XLEN;
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_tick;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_eff_wr;
    logic             w_qual;
    logic             w_step;
    logic             w_wrap;
    logic [XLEN-1:0]  w_hi_ext;
    logic [XLEN-1:0]  w_old;
    logic [XLEN-1:0]  w_new;

    generate
        if (WIDTH <= XLEN || WIDTH > 2*XLEN || PRESCALE < 1) begin : g_param_check
            $error("csr_counter_wide: illegal WIDTH/XLEN/PRESCALE combination");
        end
    endgenerate

    // rw_mode 00 is a non-write even with wr_en high, letting the increment through
    assign w_eff_wr = bus.wr_en & (bus.rw_mode != 2'b00);
    assign w_qual   = bus.inc & ~bus.inhibit;

`ifdef CSR_COUNTER_PRESCALE_EN
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int              c_pw      = $clog2(PRESCALE);
            localparam logic [c_pw-1:0] c_pre_max = c_pw'(PRESCALE - 1);
            logic [c_pw-1:0] r_pre;

            // Count qualified events; a write restarts the count from zero
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_pre <= '0;
                else if (w_eff_wr)
                    r_pre <= '0;
                else if (w_qual)
                    r_pre <= (r_pre == c_pre_max) ? '0 : r_pre + c_pw'(1);
            end

            assign w_step = w_qual & (r_pre == c_pre_max);
        end else begin : g_no_prescale
            assign w_step = w_qual;
        end
    endgenerate
`else
    assign w_step = w_qual;
`endif

    // High half zero-extended so both halves share one XLEN-wide write path
    always_comb begin
        w_hi_ext           = '0;
        w_hi_ext[c_hw-1:0] = r_cnt[WIDTH-1:XLEN];
    end

    assign w_old = bus.half_sel ? w_hi_ext : r_cnt[XLEN-1:0];

    // CSR read-modify-write operand for the selected half
    always_comb begin
        case (bus.rw_mode)
            2'b01:   w_new = bus.wdata;
            2'b10:   w_new = w_old | bus.wdata;
            2'b11:   w_new = w_old & ~bus.wdata;
            default: w_new = w_old;
        endcase
    end

    // Next count: a write wins and drops that cycle's increment entirely
    always_comb begin
        w_cnt_next = r_cnt;
        w_wrap     = 1'b0;
        if (w_eff_wr) begin
            if (bus.half_sel)
                w_cnt_next[WIDTH-1:XLEN] = w_new[c_hw-1:0];
            else
                w_cnt_next[XLEN-1:0] = w_new;
        end else if (w_step) begin
            w_cnt_next = r_cnt + c_one;
            w_wrap     = &r_cnt;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= RESET_VAL;
        else
            r_cnt <= w_cnt_next;
    end

    // Sticky overflow: a wrap beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_wrap)
            r_ovf <= 1'b1;
        else if (bus.ovf_clr || (w_eff_wr && bus.half_sel))
            r_ovf <= 1'b0;
    end

    // One-cycle pulse marking an applied increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tick <= 1'b0;
        else
            r_tick <= w_step & ~w_eff_wr;
    end

    assign bus.rdata_lo = r_cnt[XLEN-1:0];
    assign bus.rdata_hi = w_hi_ext;
    assign bus.ovf      = r_ovf;
    assign bus.tick     = r_tick;

endmodule
`default_nettype wire
